// File: rtl/order_msg_fifo.sv
// order_msg_fifo
// Buffers decoded order messages between the message parser and the
// order-book logic. The parser strobes one message per cycle at most, with
// no back-pressure; the consumer drains through a valid/ready handshake.
// Messages with illegal operation codes are dropped. A legal message that
// arrives while the FIFO is full is lost, and this sets a sticky overflow flag.
// Output is first-word-fall-through, and the head fields read as zero while empty.
//
// Optional feature macro: ORDER_FIFO_STATS_EN
//   When defined, the block adds saturating 16-bit counters of accepted
//   pushes and dropped messages. Dropped messages are illegal codes plus
//   overflow losses.
module order_msg_fifo #(
    parameter int PRICE_WIDTH = 15,
    parameter int ID_WIDTH    = 15,
    parameter int QUANT_WIDTH = 7,
    parameter int STOCK_WIDTH = 7,
    parameter int DEPTH       = 8
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     msg_valid_in,
    input  logic [2:0]               operation_in,
    input  logic [STOCK_WIDTH:0]     stock_symbol_in,
    input  logic [ID_WIDTH:0]        order_id_in,
    input  logic [PRICE_WIDTH:0]     price_in,
    input  logic [QUANT_WIDTH:0]     quantity_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [2:0]               operation_out,
    output logic [STOCK_WIDTH:0]     stock_symbol_out,
    output logic [ID_WIDTH:0]        order_id_out,
    output logic [PRICE_WIDTH:0]     price_out,
    output logic [QUANT_WIDTH:0]     quantity_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out
`ifdef ORDER_FIFO_STATS_EN
    ,
    output logic [15:0]              accepted_cnt_out,
    output logic [15:0]              dropped_cnt_out
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]           operation;
        logic [STOCK_WIDTH:0] stock_symbol;
        logic [ID_WIDTH:0]    order_id;
        logic [PRICE_WIDTH:0] price;
        logic [QUANT_WIDTH:0] quantity;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            legal;
    logic            full;
    logic            pop;
    logic            push;
    logic            lost;
    entry_t          new_entry;
    entry_t          head;

    // Decode the handshake. Because a pop frees a slot in the same cycle,
    // a full FIFO can still accept a push when the consumer pops.
    always_comb begin
        legal     = (operation_in >= 3'd1) && (operation_in <= 3'd4);
        full      = (count_q == FULL_COUNT);
        pop       = (count_q != '0) && ready_in;
        push      = msg_valid_in && legal && (!full || pop);
        lost      = msg_valid_in && legal && full && !pop;
        new_entry = '{operation:    operation_in,
                      stock_symbol: stock_symbol_in,
                      order_id:     order_id_in,
                      price:        price_in,
                      quantity:     quantity_in};
    end

    // Compute the next storage, pointer, occupancy and overflow state.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | lost;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register the FIFO state. Reset discards every stored entry.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Present the head entry fall-through style, and force it to zero while empty.
    // The head slot is never written while occupied, so a stalled head holds steady.
    always_comb begin
        head             = mem_q[rd_ptr_q];
        valid_out        = (count_q != '0);
        operation_out    = valid_out ? head.operation    : '0;
        stock_symbol_out = valid_out ? head.stock_symbol : '0;
        order_id_out     = valid_out ? head.order_id     : '0;
        price_out        = valid_out ? head.price        : '0;
        quantity_out     = valid_out ? head.quantity     : '0;
        count_out        = count_q;
        overflow_out     = overflow_q;
    end

`ifdef ORDER_FIFO_STATS_EN
    logic [15:0] accepted_cnt_q, accepted_cnt_d;
    logic [15:0] dropped_cnt_q, dropped_cnt_d;
    logic        dropped_event;

    // Advance the saturating statistics counters on accepted and dropped messages.
    always_comb begin
        dropped_event  = (msg_valid_in && !legal) || lost;
        accepted_cnt_d = accepted_cnt_q;
        dropped_cnt_d  = dropped_cnt_q;
        if (push && (accepted_cnt_q != 16'hFFFF)) begin
            accepted_cnt_d = accepted_cnt_q + 16'd1;
        end
        if (dropped_event && (dropped_cnt_q != 16'hFFFF)) begin
            dropped_cnt_d = dropped_cnt_q + 16'd1;
        end
    end

    // Register the statistics counters.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            accepted_cnt_q <= '0;
            dropped_cnt_q  <= '0;
        end else begin
            accepted_cnt_q <= accepted_cnt_d;
            dropped_cnt_q  <= dropped_cnt_d;
        end
    end

    assign accepted_cnt_out = accepted_cnt_q;
    assign dropped_cnt_out  = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_order_msg_fifo.sv
// tb_order_msg_fifo
// Scoreboard bench for order_msg_fifo. Accepted messages are queued as they
// are driven. The head of the queue is compared with the DUT's fall-through
// output every cycle and popped when the consumer handshake completes.
module tb_order_msg_fifo;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        msg_valid_in;
    logic [2:0]  operation_in;
    logic [7:0]  stock_symbol_in;
    logic [15:0] order_id_in;
    logic [15:0] price_in;
    logic [7:0]  quantity_in;
    logic        valid_out;
    logic        ready_in;
    logic [2:0]  operation_out;
    logic [7:0]  stock_symbol_out;
    logic [15:0] order_id_out;
    logic [15:0] price_out;
    logic [7:0]  quantity_out;
    logic [3:0]  count_out;
    logic        overflow_out;
`ifdef ORDER_FIFO_STATS_EN
    logic [15:0] accepted_cnt_out;
    logic [15:0] dropped_cnt_out;
`endif

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  stock;
        logic [15:0] id;
        logic [15:0] price;
        logic [7:0]  qty;
    } msg_t;

    msg_t        sb[$];
    bit          modelOverflow;
    int unsigned modelAccepted;
    int unsigned modelDropped;
    int          checks;
    int          failures;

    order_msg_fifo dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .msg_valid_in     (msg_valid_in),
        .operation_in     (operation_in),
        .stock_symbol_in  (stock_symbol_in),
        .order_id_in      (order_id_in),
        .price_in         (price_in),
        .quantity_in      (quantity_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .operation_out    (operation_out),
        .stock_symbol_out (stock_symbol_out),
        .order_id_out     (order_id_out),
        .price_out        (price_out),
        .quantity_out     (quantity_out),
        .count_out        (count_out),
`ifdef ORDER_FIFO_STATS_EN
        .accepted_cnt_out (accepted_cnt_out),
        .dropped_cnt_out  (dropped_cnt_out),
`endif
        .overflow_out     (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with the scoreboard model.
    task automatic checkAll();
        msg_t head;
        bit   nonEmpty;
        nonEmpty = (sb.size() != 0);
        head     = nonEmpty ? sb[0] : msg_t'(0);
        checkOutput("valid_out", 64'(valid_out), 64'(nonEmpty));
        checkOutput("count_out", 64'(count_out), 64'(sb.size()));
        checkOutput("overflow_out", 64'(overflow_out), 64'(modelOverflow));
        checkOutput("operation_out", 64'(operation_out), 64'(head.op));
        checkOutput("stock_symbol_out", 64'(stock_symbol_out), 64'(head.stock));
        checkOutput("order_id_out", 64'(order_id_out), 64'(head.id));
        checkOutput("price_out", 64'(price_out), 64'(head.price));
        checkOutput("quantity_out", 64'(quantity_out), 64'(head.qty));
`ifdef ORDER_FIFO_STATS_EN
        checkOutput("accepted_cnt_out", 64'(accepted_cnt_out), 64'(modelAccepted));
        checkOutput("dropped_cnt_out", 64'(dropped_cnt_out), 64'(modelDropped));
`endif
    endtask

    // One clock cycle. Called at a negedge: check outputs, drive inputs,
    // update the model with this cycle's push/pop, then advance to the next negedge.
    task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [7:0] stock,
                                 input logic [15:0] id, input logic [15:0] price,
                                 input logic [7:0] qty, input bit rdy);
        msg_t m;
        bit   legal;
        checkAll();
        msg_valid_in    = v;
        operation_in    = op;
        stock_symbol_in = stock;
        order_id_in     = id;
        price_in        = price;
        quantity_in     = qty;
        ready_in        = rdy;
        legal = (op >= 3'd1) && (op <= 3'd4);
        if (rdy && sb.size() != 0) void'(sb.pop_front());
        if (v && legal) begin
            if (sb.size() < 8) begin
                m = '{op: op, stock: stock, id: id, price: price, qty: qty};
                sb.push_back(m);
                if (modelAccepted < 16'hFFFF) modelAccepted++;
            end else begin
                modelOverflow = 1'b1;
                if (modelDropped < 16'hFFFF) modelDropped++;
            end
        end else if (v) begin
            if (modelDropped < 16'hFFFF) modelDropped++;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Legal message derived from an id, so every field is distinct per message.
    task automatic sendId(input logic [15:0] id, input bit rdy);
        applyStimulus(1'b1, 3'(1 + (id % 4)), id[7:0] ^ 8'h5A, id, id * 16'd3 + 16'd7,
                      id[7:0] + 8'd1, rdy);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 3'd0, 8'd0, 16'd0, 16'd0, 8'd0, rdy);
    endtask

    // Pulse reset for one edge and clear the model.
    task automatic doReset();
        reset_in     = 1'b1;
        msg_valid_in = 1'b0;
        ready_in     = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        reset_in      = 1'b0;
        sb.delete();
        modelOverflow = 1'b0;
        modelAccepted = 0;
        modelDropped  = 0;
        checkOutput("reset_valid", 64'(valid_out), 64'd0);
        checkOutput("reset_count", 64'(count_out), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_out), 64'd0);
        checkOutput("reset_fields", {order_id_out, price_out, stock_symbol_out, quantity_out,
                                     5'd0, operation_out}, 64'd0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        msg_valid_in    = 1'b0;
        operation_in    = '0;
        stock_symbol_in = '0;
        order_id_in     = '0;
        price_in        = '0;
        quantity_in     = '0;
        ready_in        = 1'b0;
        reset_in        = 1'b1;
        @(negedge clk_in);
        doReset();

        $display("[TB] single ADD then stall");
        applyStimulus(1'b1, 3'd1, 8'h2A, 16'h1234, 16'd500, 8'd10, 1'b0);
        checkOutput("add_id_after_1cycle", 64'(order_id_out), 64'h1234);
        for (int i = 0; i < 5; i++) idle(1'b0);
        checkOutput("add_price_stable", 64'(price_out), 64'd500);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] illegal codes dropped");
        applyStimulus(1'b1, 3'd0, 8'h11, 16'h0BAD, 16'd1, 8'd1, 1'b0);
        applyStimulus(1'b1, 3'd7, 8'h22, 16'h0BAD, 16'd2, 8'd2, 1'b0);
        applyStimulus(1'b1, 3'd5, 8'h33, 16'h0BAD, 16'd3, 8'd3, 1'b0);
        idle(1'b0);
        checkOutput("illegal_count", 64'(count_out), 64'd0);

        $display("[TB] overflow on ninth message");
        doReset();
        for (int i = 1; i <= 9; i++) sendId(16'(i), 1'b0);
        idle(1'b0);
        checkOutput("overflow_set", 64'(overflow_out), 64'd1);
        checkOutput("full_count", 64'(count_out), 64'd8);
        for (int i = 0; i < 9; i++) idle(1'b1);
        checkOutput("drained_empty", 64'(valid_out), 64'd0);

        $display("[TB] push and pop together when full");
        doReset();
        for (int i = 1; i <= 8; i++) sendId(16'(i), 1'b0);
        sendId(16'd9, 1'b1);
        checkOutput("full_pushpop_count", 64'(count_out), 64'd8);
        checkOutput("full_pushpop_overflow", 64'(overflow_out), 64'd0);
        checkOutput("full_pushpop_head", 64'(order_id_out), 64'd2);
        for (int i = 0; i < 9; i++) idle(1'b1);

        $display("[TB] back-to-back streaming");
        for (int i = 100; i < 120; i++) begin
            checkOutput("stream_count_le1", 64'(count_out <= 4'd1), 64'd1);
            sendId(16'(i), 1'b1);
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0)
                applyStimulus(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom),
                              16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 1) == 1)
                sendId(16'($urandom), $urandom_range(0, 2) == 0);
            else
                idle($urandom_range(0, 1) == 1);
        end

        $display("[TB] reset with entries and overflow");
        doReset();
        for (int i = 1; i <= 9; i++) sendId(16'(i + 200), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        idle(1'b0);
        checkOutput("pre_reset_count", 64'(count_out), 64'd3);
        checkOutput("pre_reset_overflow", 64'(overflow_out), 64'd1);
        doReset();
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
